// File: rtl/delay_line_ctrl.sv
// Circular-buffer write/read controller for the delay-line RAM.
// The output stream repeats the input stream `offset` samples later, with zeros until the buffer is primed.
module delay_line_ctrl #(
    parameter int unsigned ADDRESS_WIDTH = 9,
    parameter int unsigned DATA_WIDTH    = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic                     stop,
    input  logic [ADDRESS_WIDTH-1:0] offset,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [DATA_WIDTH-1:0]    in_data,
    output logic                     out_valid,
    output logic [DATA_WIDTH-1:0]    out_data,
    output logic                     busy,
    output logic [ADDRESS_WIDTH-1:0] w_addr,
    output logic                     w_en,
    output logic [DATA_WIDTH-1:0]    din,
    output logic [ADDRESS_WIDTH-1:0] r_addr,
    output logic                     r_en,
    input  logic [DATA_WIDTH-1:0]    ram_dout
);

    typedef enum logic [1:0] {StIdle, StFill, StRun} state_e;

    state_e                   state_q, state_d;
    logic [ADDRESS_WIDTH-1:0] off_q, off_d;
    logic [ADDRESS_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDRESS_WIDTH-1:0] fill_cnt_q, fill_cnt_d;
    logic                     out_valid_q;
    logic                     zero_q;
    logic                     bypass_q;
    logic [DATA_WIDTH-1:0]    data_q;
    logic                     accept;

    assign busy     = (state_q != StIdle);
    assign in_ready = busy;
    assign accept   = in_valid & in_ready;

    assign w_en   = accept;
    assign r_en   = accept;
    assign w_addr = wr_ptr_q;
    assign r_addr = wr_ptr_q - off_q;
    assign din    = accept ? in_data : '0;

    always_comb begin
        state_d    = state_q;
        off_d      = off_q;
        wr_ptr_d   = wr_ptr_q;
        fill_cnt_d = fill_cnt_q;
        unique case (state_q)
            StIdle: begin
                if (start && !stop) begin
                    off_d      = offset;
                    wr_ptr_d   = '0;
                    fill_cnt_d = '0;
                    state_d    = (offset == '0) ? StRun : StFill;
                end
            end
            StFill: begin
                if (accept) begin
                    fill_cnt_d = fill_cnt_q + ADDRESS_WIDTH'(1);
                    if (fill_cnt_d == off_q) state_d = StRun;
                end
                if (stop) state_d = StIdle;
            end
            StRun: begin
                if (stop) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
        // A sample accepted alongside stop is still written.
        if (accept) wr_ptr_d = wr_ptr_q + ADDRESS_WIDTH'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            off_q      <= '0;
            wr_ptr_q   <= '0;
            fill_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            off_q      <= off_d;
            wr_ptr_q   <= wr_ptr_d;
            fill_cnt_q <= fill_cnt_d;
        end
    end

    // With a zero offset the RAM read returns the previous occupant, so the sample is forwarded.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            zero_q      <= 1'b0;
            bypass_q    <= 1'b0;
            data_q      <= '0;
        end else begin
            out_valid_q <= accept;
            if (accept) begin
                zero_q   <= (state_q == StFill);
                bypass_q <= (off_q == '0);
                data_q   <= in_data;
            end
        end
    end

    always_comb begin
        out_data = '0;
        if (out_valid_q && !zero_q) out_data = bypass_q ? data_q : ram_dout;
    end

    assign out_valid = out_valid_q;

endmodule

// File: tb/tb_delay_line_ctrl.sv
// Bench for delay_line_ctrl: behavioural RAM, directed streams, queue scoreboard.
module tb_delay_line_ctrl;
    localparam int AW = 4;
    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          stop = 1'b0;
    logic [AW-1:0] offset = '0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [DW-1:0] in_data = '0;
    logic          out_valid;
    logic [DW-1:0] out_data;
    logic          busy;
    logic [AW-1:0] w_addr;
    logic          w_en;
    logic [DW-1:0] din;
    logic [AW-1:0] r_addr;
    logic          r_en;
    logic [DW-1:0] ram_dout;

    delay_line_ctrl #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .offset(offset),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_data(out_data), .busy(busy),
        .w_addr(w_addr), .w_en(w_en), .din(din), .r_addr(r_addr), .r_en(r_en),
        .ram_dout(ram_dout)
    );

    always #5 clk = ~clk;

    // Registered-read RAM; a same-address read returns the old word.
    logic [DW-1:0] mem [2**AW];
    always @(posedge clk) begin
        if (r_en) ram_dout <= mem[r_addr];
        if (w_en) mem[w_addr] <= din;
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int            checks = 0;
    int            failures = 0;
    int            due_q[$];
    logic [DW-1:0] exp_q[$];
    int            wp = 0;
    int            off_b = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (due_q.size() > 0 && due_q[0] < cyc) begin
            checks++;
            failures++;
            $display("FAIL missing_out: got no out_valid expected data %0h at cycle %0d",
                     exp_q[0], due_q[0]);
            void'(due_q.pop_front());
            void'(exp_q.pop_front());
        end
        if (out_valid) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_out: got out_valid data %0h expected none", out_data);
            end else begin
                chk("out_cycle", cyc, due_q[0]);
                chk("out_data", out_data, exp_q[0]);
                void'(due_q.pop_front());
                void'(exp_q.pop_front());
            end
        end else begin
            chk("idle_out_data", out_data, 0);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input int o);
        in_valid = 1'b0;
        offset   = o[AW-1:0];
        start    = 1'b1;
        step();
        start = 1'b0;
        wp    = 0;
        off_b = o;
        chk("start_busy", busy, 1);
        chk("start_ready", in_ready, 1);
    endtask

    task automatic send(input logic [DW-1:0] d, input logic [DW-1:0] e);
        logic [AW-1:0] ea;
        logic [AW-1:0] er;
        ea = AW'(wp);
        er = AW'(wp - off_b);
        in_valid = 1'b1;
        in_data  = d;
        #1;
        chk("w_en", w_en, 1);
        chk("r_en", r_en, 1);
        chk("w_addr", w_addr, ea);
        chk("r_addr", r_addr, er);
        chk("din", din, d);
        due_q.push_back(cyc + 1);
        exp_q.push_back(e);
        wp++;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) step();
    endtask

    task automatic do_stop();
        in_valid = 1'b0;
        stop     = 1'b1;
        step();
        stop = 1'b0;
        chk("stop_ready", in_ready, 0);
        chk("stop_busy", busy, 0);
    endtask

    initial begin
        // Reset and idle: nothing moves even with in_valid high.
        repeat (3) step();
        rst_n    = 1'b1;
        in_valid = 1'b1;
        in_data  = 8'h33;
        repeat (5) begin
            step();
            chk("idle_ready", in_ready, 0);
            chk("idle_busy", busy, 0);
            chk("idle_w_en", w_en, 0);
            chk("idle_r_en", r_en, 0);
            chk("idle_din", din, 0);
            chk("idle_w_addr", w_addr, 0);
            chk("idle_r_addr", r_addr, 0);
            chk("idle_out_valid", out_valid, 0);
        end
        in_valid = 1'b0;

        // start with stop in IDLE: stop wins.
        offset = 4'd5;
        start  = 1'b1;
        stop   = 1'b1;
        step();
        start = 1'b0;
        stop  = 1'b0;
        chk("startstop_busy", busy, 0);
        chk("startstop_ready", in_ready, 0);

        // offset=3, 1..10 back to back; offset input changed mid-run has no effect.
        do_start(3);
        offset = 4'd7;
        for (int k = 1; k <= 10; k++) send(8'(k), (k > 3) ? 8'(k - 3) : 8'h00);
        do_stop();
        idle(2);

        // Bypass: addresses coincide, RAM holds stale data from the previous run.
        do_start(0);
        send(8'hA5, 8'hA5);
        send(8'h5A, 8'h5A);
        do_stop();
        idle(2);

        // Maximum offset with address wrap.
        do_start(15);
        for (int k = 0; k < 40; k++) send(8'(k + 16), (k >= 15) ? 8'(k - 15 + 16) : 8'h00);
        do_stop();
        idle(2);

        // Gapped input: delay counts samples, not cycles.
        do_start(2);
        for (int k = 0; k < 6; k++) begin
            send(8'(8'h40 + k), (k >= 2) ? 8'(8'h40 + k - 2) : 8'h00);
            idle(2);
        end
        do_stop();
        idle(2);

        // stop coincident with an accept.
        do_start(1);
        send(8'h71, 8'h00);
        send(8'h72, 8'h71);
        in_valid = 1'b1;
        in_data  = 8'h73;
        stop     = 1'b1;
        due_q.push_back(cyc + 1);
        exp_q.push_back(8'h72);
        step();
        stop     = 1'b0;
        in_valid = 1'b0;
        chk("stop_accept_ready", in_ready, 0);
        chk("stop_accept_valid", out_valid, 1);
        idle(2);

        // Asynchronous reset while an output is being presented.
        do_start(2);
        send(8'h81, 8'h00);
        send(8'h82, 8'h00);
        send(8'h83, 8'h81);
        in_valid = 1'b0;
        chk("pre_reset_valid", out_valid, 1);
        rst_n = 1'b0;
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_ready", in_ready, 0);
        chk("rst_busy", busy, 0);
        due_q.delete();
        exp_q.delete();
        step();
        rst_n = 1'b1;
        step();

        // New run after reset: first four outputs zero despite stale RAM.
        do_start(4);
        for (int k = 0; k < 6; k++) send(8'(8'h90 + k), (k >= 4) ? 8'(8'h90 + k - 4) : 8'h00);
        do_stop();
        idle(3);

        chk("scoreboard_drain", due_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
